// File: rtl/block_put_pkg.sv
// Shared defaults and state encoding for the block extract/put datapath.
package block_put_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_J      = 2;
  localparam int DEF_K      = 2;
  localparam int DEF_ADDR_W = 10;
  localparam int IDX_W      = 10;
  localparam int WIDE_W     = 2 * IDX_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } blk_state_e;
endpackage

// File: rtl/block_put_if.sv
// Single-port matrix memory bus: one element per slot, read data one cycle after mem_re.
interface block_put_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_we, mem_re, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_we, mem_re, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/block_addr_gen.sv
// Block element (i,j) to linear matrix address plus clip flag; shared with block_get.
module block_addr_gen
  import block_put_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [IDX_W-1:0]  start_row,
  input  logic [IDX_W-1:0]  start_col,
  input  logic [IDX_W-1:0]  num_cols,
  input  logic [IDX_W-1:0]  matrix_len,
  input  logic [IDX_W-1:0]  i,
  input  logic [IDX_W-1:0]  j,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  logic [IDX_W:0]    row;
  logic [IDX_W:0]    col;
  logic [WIDE_W-1:0] lin;

  // Full-width arithmetic so large coordinates can never alias back into range.
  always_comb begin
    row      = {1'b0, start_row} + {1'b0, i};
    col      = {1'b0, start_col} + {1'b0, j};
    lin      = WIDE_W'(row) * WIDE_W'(num_cols) + WIDE_W'(col);
    in_range = (WIDE_W'(col) < WIDE_W'(num_cols)) && (lin < WIDE_W'(matrix_len));
    addr     = lin[ADDR_W-1:0];
  end
endmodule

// File: rtl/block_put.sv
// Scatters a JxK block into row-major matrix memory with clipping and optional accumulate.
// state | meaning: IDLE wait start | SCAN clipped element | READ acc read | WRITE write slot | DONE pulse
module block_put
  import block_put_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int J      = DEF_J,
  parameter int K      = DEF_K,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    accumulate,
  input  logic [IDX_W-1:0]        start_row,
  input  logic [IDX_W-1:0]        start_col,
  input  logic [IDX_W-1:0]        num_cols,
  input  logic [IDX_W-1:0]        matrix_len,
  input  logic [J*K*DATA_W-1:0]   block_in,
  block_put_if.master             mem,
  output logic                    busy,
  output logic                    done
);
  blk_state_e              state;
  logic [IDX_W-1:0]        row_q, col_q, ncols_q, len_q, cur_i, cur_j;
  logic [IDX_W-1:0]        g_row, g_col, g_ncols, g_len, nxt_i, nxt_j;
  logic                    acc_q, g_acc, g_in_range, last, issue;
  logic                    we_q, re_q, acc_wr;
  logic [J*K*DATA_W-1:0]   blk_q, g_blk;
  logic [DATA_W-1:0]       elem, wdata_q;
  logic [ADDR_W-1:0]       g_addr, addr_q;

  // In IDLE the first element is issued straight from the inputs so its slot lands in cycle 1.
  always_comb begin
    g_row   = row_q;
    g_col   = col_q;
    g_ncols = ncols_q;
    g_len   = len_q;
    g_acc   = acc_q;
    g_blk   = blk_q;
    nxt_i   = cur_i;
    nxt_j   = cur_j + IDX_W'(1);
    if (cur_j == IDX_W'(K - 1)) begin
      nxt_i = cur_i + IDX_W'(1);
      nxt_j = '0;
    end
    if (state == ST_IDLE) begin
      g_row   = start_row;
      g_col   = start_col;
      g_ncols = num_cols;
      g_len   = matrix_len;
      g_acc   = accumulate;
      g_blk   = block_in;
      nxt_i   = '0;
      nxt_j   = '0;
    end
    last  = (cur_i == IDX_W'(J - 1)) && (cur_j == IDX_W'(K - 1));
    issue = (state == ST_IDLE) ? start : ((state == ST_SCAN || state == ST_WRITE) && !last);
    elem  = '0;
    for (int e = 0; e < J * K; e++) begin
      if (IDX_W'(e) == nxt_i * IDX_W'(K) + nxt_j) elem = g_blk[e*DATA_W +: DATA_W];
    end
  end

  block_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .start_row  (g_row),
    .start_col  (g_col),
    .num_cols   (g_ncols),
    .matrix_len (g_len),
    .i          (nxt_i),
    .j          (nxt_j),
    .addr       (g_addr),
    .in_range   (g_in_range)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      ncols_q <= '0;
      len_q   <= '0;
      acc_q   <= 1'b0;
      blk_q   <= '0;
      cur_i   <= '0;
      cur_j   <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      acc_wr  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (issue) begin
        if (state == ST_IDLE) begin
          row_q   <= start_row;
          col_q   <= start_col;
          ncols_q <= num_cols;
          len_q   <= matrix_len;
          acc_q   <= accumulate;
          blk_q   <= block_in;
        end
        cur_i  <= nxt_i;
        cur_j  <= nxt_j;
        busy   <= 1'b1;
        we_q   <= g_in_range && !g_acc;
        re_q   <= g_in_range && g_acc;
        acc_wr <= 1'b0;
        if (g_in_range) begin
          addr_q  <= g_addr;
          wdata_q <= elem;
        end
        state <= !g_in_range ? ST_SCAN : (g_acc ? ST_READ : ST_WRITE);
      end else begin
        case (state)
          ST_READ: begin
            re_q   <= 1'b0;
            we_q   <= 1'b1;
            acc_wr <= 1'b1;
            state  <= ST_WRITE;
          end
          ST_SCAN, ST_WRITE: begin
            we_q   <= 1'b0;
            acc_wr <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Read data arrives during the WRITE cycle, so the accumulate sum is formed there.
  assign mem.mem_we    = we_q;
  assign mem.mem_re    = re_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = acc_wr ? (mem.mem_rdata + wdata_q) : wdata_q;
endmodule

// File: tb/tb_block_put.sv
// Directed bench for block_put with a synchronous-read memory model.
module tb_block_put;
  localparam int DW = 16;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        accumulate = 1'b0;
  logic [9:0]  start_row = '0, start_col = '0, num_cols = '0, matrix_len = '0;
  logic [63:0] block_in = '0;
  logic        busy, done;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rdata_q = '0;
  logic          pre_we = 1'b0, pre_clr = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  int errors = 0;
  int checks = 0;
  int we_cyc[$], re_cyc[$];
  logic [AW-1:0] we_adr[$];
  logic [DW-1:0] we_dat[$];
  int overlap, busy_c1, dcyc;

  always #5 clk = ~clk;

  block_put_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  block_put #(.DATA_W(DW), .J(2), .K(2), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .accumulate (accumulate),
    .start_row  (start_row),
    .start_col  (start_col),
    .num_cols   (num_cols),
    .matrix_len (matrix_len),
    .block_in   (block_in),
    .mem        (bus),
    .busy       (busy),
    .done       (done)
  );

  assign bus.mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (pre_clr) for (int a = 0; a < 1024; a++) mem[a] <= '0;
    if (bus.mem_re) rdata_q <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Starts one request and logs strobes per cycle (accept edge = cycle 0) until done.
  task automatic run_op(input logic acc, input logic [9:0] r, input logic [9:0] c,
                        input logic [9:0] nc, input logic [9:0] len, input logic [63:0] blk,
                        input int poke);
    we_cyc.delete(); re_cyc.delete(); we_adr.delete(); we_dat.delete();
    overlap = 0; busy_c1 = 0; dcyc = -1;
    @(negedge clk);
    accumulate = acc; start_row = r; start_col = c; num_cols = nc; matrix_len = len;
    block_in = blk; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 60 && dcyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) busy_c1 = int'(busy);
      if (bus.mem_we) begin
        we_cyc.push_back(cyc); we_adr.push_back(bus.mem_addr); we_dat.push_back(bus.mem_wdata);
      end
      if (bus.mem_re) re_cyc.push_back(cyc);
      if (bus.mem_we && bus.mem_re) overlap++;
      if (done) dcyc = cyc;
      if (cyc == poke) begin
        start = 1'b1; accumulate = 1'b1; start_row = 10'd2; start_col = 10'd2;
        block_in = 64'hAAAA_BBBB_CCCC_DDDD;
      end
      if (cyc == poke + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  initial begin
    pre_clr = 1'b1;
    repeat (2) @(negedge clk);
    pre_clr = 1'b0;
    chk("rst_we", bus.mem_we, 0);
    chk("rst_re", bus.mem_re, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    rst = 1'b0;

    // 1: overwrite at (1,1)
    run_op(1'b0, 10'd1, 10'd1, 10'd4, 10'd16, {16'd4, 16'd3, 16'd2, 16'd1}, -10);
    chk("t1_busy_c1", busy_c1, 1);
    chk("t1_nwr", we_cyc.size(), 4);
    chk("t1_a0", we_adr[0], 5);  chk("t1_a1", we_adr[1], 6);
    chk("t1_a2", we_adr[2], 9);  chk("t1_a3", we_adr[3], 10);
    chk("t1_d0", we_dat[0], 1);  chk("t1_d3", we_dat[3], 4);
    chk("t1_c0", we_cyc[0], 1);  chk("t1_c3", we_cyc[3], 4);
    chk("t1_done", dcyc, 5);
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    chk("t1_mem10", mem[10], 4);

    // 2: clip at (3,3), only element 0 lands
    run_op(1'b0, 10'd3, 10'd3, 10'd4, 10'd16, 64'h0044_0033_0022_0011, -10);
    chk("t2_nwr", we_cyc.size(), 1);
    chk("t2_a0", we_adr[0], 15);
    chk("t2_d0", we_dat[0], 16'h11);
    chk("t2_done", dcyc, 5);

    // 3: accumulate
    preload(10'd5, 16'd10); preload(10'd6, 16'd20);
    preload(10'd9, 16'd30); preload(10'd10, 16'd40);
    run_op(1'b1, 10'd1, 10'd1, 10'd4, 10'd16, {16'd4, 16'd3, 16'd2, 16'd1}, -10);
    @(negedge clk);
    chk("t3_m5", mem[5], 11);  chk("t3_m6", mem[6], 22);
    chk("t3_m9", mem[9], 33);  chk("t3_m10", mem[10], 44);
    chk("t3_re0", re_cyc[0], 1); chk("t3_we0", we_cyc[0], 2);
    chk("t3_re3", re_cyc[3], 7); chk("t3_we3", we_cyc[3], 8);
    chk("t3_overlap", overlap, 0);
    chk("t3_done", dcyc, 9);

    // 4: accumulate wraps modulo 2^16
    preload(10'd0, 16'hFFFF);
    run_op(1'b1, 10'd0, 10'd0, 10'd4, 10'd16, 64'h0000_0000_0000_0002, -10);
    @(negedge clk);
    chk("t4_wrap", mem[0], 16'h0001);
    chk("t4_m5", mem[5], 11);
    chk("t4_done", dcyc, 9);

    // 5: start while busy is ignored
    run_op(1'b0, 10'd0, 10'd0, 10'd4, 10'd16, {16'd8, 16'd7, 16'd6, 16'd5}, 2);
    chk("t5_nwr", we_cyc.size(), 4);
    chk("t5_a3", we_adr[3], 5);
    chk("t5_d3", we_dat[3], 8);
    chk("t5_done", dcyc, 5);
    repeat (3) @(negedge clk);
    chk("t5_no_restart", busy, 0);
    chk("t5_m10", mem[10], 44);

    // 6: reset after the second write
    @(negedge clk);
    accumulate = 1'b0; start_row = 10'd1; start_col = 10'd1; num_cols = 10'd4;
    matrix_len = 10'd16; block_in = {16'd4, 16'd3, 16'd2, 16'd1}; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_we_drop", bus.mem_we, 0);
    chk("t6_busy_drop", busy, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t6_no_done", done, 0);
    end
    rst = 1'b0;
    chk("t6_m5", mem[5], 1);
    chk("t6_m6", mem[6], 2);
    chk("t6_m9_kept", mem[9], 33);
    run_op(1'b0, 10'd2, 10'd0, 10'd4, 10'd16, {16'd4, 16'd3, 16'd2, 16'd1}, -10);
    @(negedge clk);
    chk("t6_fresh_done", dcyc, 5);
    chk("t6_fresh_m9", mem[9], 2);
    chk("t6_fresh_m13", mem[13], 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
